spi_uid_responder: RTL and testbench

SPI slave (responder) running on CLOCK_50 that answers the security-system SPI master's UID-poll and state-report transactions, taking the place of the soft-SPI card-reader node. It decodes command bytes on MOSI, returns a 4-byte card UID on MISO after a 0xAA poll, and latches the 2-bit system-state code carried by the 0xBA–0xBD commands. It sits between the GPIO SPI pins and the card-reader and status logic.

---
 rtl/spi_uid_responder_if.sv | 25 ++
 rtl/spi_uid_responder.sv | 176 +++++++++++++++++
 tb/tb_spi_uid_responder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_uid_responder_if.sv
// SPI pin bundle plus card/status signals shared by the UID responder and its neighbours.
interface spi_uid_responder_if;
  logic        spi_clk;
  logic        ss;
  logic        mosi;
  logic        miso;
  logic [31:0] uid;
  logic        uid_present;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [1:0]  sys_state;
  logic        sys_state_valid;
  logic        frame_err;
  logic        busy;

  modport slave (
    input  spi_clk, ss, mosi, uid, uid_present,
    output miso, rx_data, rx_valid, sys_state, sys_state_valid, frame_err, busy
  );

  modport master (
    output spi_clk, ss, mosi, uid, uid_present,
    input  miso, rx_data, rx_valid, sys_state, sys_state_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_uid_responder.sv
// Mode-0 SPI slave on CLOCK_50: answers 0xAA UID polls with a 4-byte snapshot
// and latches the 2-bit system state carried by commands 0xBA..0xBD.
module spi_uid_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_RESP   = 8'h00
) (
  input logic                CLOCK_50,
  input logic                reset,
  spi_uid_responder_if.slave bus
);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned UID_W  = 32;
  localparam int unsigned CNT_W  = 3;
  localparam logic [BYTE_W-1:0] CMD_POLL     = 8'hAA;
  localparam logic [BYTE_W-1:0] CMD_STATE_LO = 8'hBA;
  localparam logic [BYTE_W-1:0] CMD_STATE_HI = 8'hBD;

  typedef enum logic [2:0] {
    RESP_IDLE = 3'd0,
    RESP_UID1 = 3'd1,
    RESP_UID2 = 3'd2,
    RESP_UID3 = 3'd3,
    RESP_UID4 = 3'd4
  } resp_state_e;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_d, ss_d;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;

  // Pin synchronizers; ss idles high so its chain resets to 1.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  resp_state_e        resp_state, resp_state_d;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
  logic [BYTE_W-1:0]  rx_shift, rx_shift_d;
  logic [BYTE_W-1:0]  tx_shift, tx_shift_d;
  logic [UID_W-1:0]   uid_shadow, uid_shadow_d;
  logic [BYTE_W-1:0]  rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic [1:0]         sys_state_q, sys_state_d;
  logic               sys_state_valid_q, sys_state_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               busy_q, busy_d;
  logic               miso_q, miso_d;

  function automatic logic [BYTE_W-1:0] resp_byte(input resp_state_e st,
                                                  input logic [UID_W-1:0] shadow);
    logic [BYTE_W-1:0] b;
    case (st)
      RESP_UID1: b = shadow[31:24];
      RESP_UID2: b = shadow[23:16];
      RESP_UID3: b = shadow[15:8];
      RESP_UID4: b = shadow[7:0];
      default:   b = IDLE_RESP;
    endcase
    return b;
  endfunction

  // Next-state: receive shift, transmit shift, command decode and framing.
  always_comb begin
    resp_state_d      = resp_state;
    bit_cnt_d         = bit_cnt;
    rx_shift_d        = rx_shift;
    tx_shift_d        = tx_shift;
    uid_shadow_d      = uid_shadow;
    rx_data_d         = rx_data_q;
    rx_valid_d        = 1'b0;
    sys_state_d       = sys_state_q;
    sys_state_valid_d = sys_state_valid_q;
    frame_err_d       = 1'b0;
    busy_d            = ~ss_s;

    if (ss_rise && bit_cnt != '0) begin
      bit_cnt_d   = '0;
      frame_err_d = 1'b1;
    end

    if (ss_fall) begin
      tx_shift_d = resp_byte(resp_state, uid_shadow);
    end

    if (!ss_s) begin
      // The fall right after a completed byte must not shift the freshly reloaded byte.
      if (sclk_fall && bit_cnt != '0) begin
        tx_shift_d = {tx_shift[BYTE_W-2:0], 1'b0};
      end
      if (sclk_rise) begin
        rx_shift_d = {rx_shift[BYTE_W-2:0], mosi_s};
        if (bit_cnt == CNT_W'(7)) begin
          bit_cnt_d  = '0;
          rx_data_d  = rx_shift_d;
          rx_valid_d = 1'b1;
          case (resp_state)
            RESP_IDLE: begin
              if (rx_shift_d == CMD_POLL) begin
                uid_shadow_d = bus.uid_present ? bus.uid : UID_W'(0);
                resp_state_d = RESP_UID1;
              end else if (rx_shift_d inside {[CMD_STATE_LO:CMD_STATE_HI]}) begin
                sys_state_d       = rx_shift_d[1:0] - 2'b10;
                sys_state_valid_d = 1'b1;
              end
            end
            RESP_UID4: resp_state_d = RESP_IDLE;
            default:   resp_state_d = resp_state_e'(3'(resp_state) + 3'd1);
          endcase
          tx_shift_d = resp_byte(resp_state_d, uid_shadow_d);
        end else begin
          bit_cnt_d = bit_cnt + CNT_W'(1);
        end
      end
    end

    miso_d = ~ss_s & tx_shift_d[BYTE_W-1];
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      resp_state        <= RESP_IDLE;
      bit_cnt           <= '0;
      rx_shift          <= '0;
      tx_shift          <= '0;
      uid_shadow        <= '0;
      rx_data_q         <= '0;
      rx_valid_q        <= 1'b0;
      sys_state_q       <= '0;
      sys_state_valid_q <= 1'b0;
      frame_err_q       <= 1'b0;
      busy_q            <= 1'b0;
      miso_q            <= 1'b0;
    end else begin
      resp_state        <= resp_state_d;
      bit_cnt           <= bit_cnt_d;
      rx_shift          <= rx_shift_d;
      tx_shift          <= tx_shift_d;
      uid_shadow        <= uid_shadow_d;
      rx_data_q         <= rx_data_d;
      rx_valid_q        <= rx_valid_d;
      sys_state_q       <= sys_state_d;
      sys_state_valid_q <= sys_state_valid_d;
      frame_err_q       <= frame_err_d;
      busy_q            <= busy_d;
      miso_q            <= miso_d;
    end
  end

  assign bus.miso            = miso_q;
  assign bus.rx_data         = rx_data_q;
  assign bus.rx_valid        = rx_valid_q;
  assign bus.sys_state       = sys_state_q;
  assign bus.sys_state_valid = sys_state_valid_q;
  assign bus.frame_err       = frame_err_q;
  assign bus.busy            = busy_q;
endmodule

// File: tb/tb_spi_uid_responder.sv
// Bench for spi_uid_responder: directed scenarios plus random frames, checked
// every cycle against a transaction-level model of the responder.
module tb_spi_uid_responder;
  localparam int unsigned HALF = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  spi_uid_responder_if bus();

  spi_uid_responder #(.SYNC_STAGES(2), .IDLE_RESP(8'h00)) dut (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [7:0] b; } rx_ev_t;
  rx_ev_t rxq[$];
  int     feq[$];

  // Transaction-level model state
  int          m_idx = 0;
  logic [31:0] m_shadow = '0;
  logic [7:0]  m_rx = '0;
  logic [1:0]  m_state = '0;
  logic        m_state_valid = 1'b0;

  int   rxv_count = 0;
  int   fe_count = 0;
  int   frame_bits = 0;
  logic ss_h1 = 1'b1;
  logic ss_h2 = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_resp();
    if (m_idx == 0) return 8'h00;
    return 8'((m_shadow >> (8 * (4 - m_idx))) & 32'hFF);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    m_rx = b;
    if (m_idx == 0) begin
      if (b == 8'hAA) begin
        m_shadow = bus.uid_present ? bus.uid : 32'h0;
        m_idx = 1;
      end else if (b >= 8'hBA && b <= 8'hBD) begin
        m_state = 2'(b - 8'hBA);
        m_state_valid = 1'b1;
      end
    end else begin
      m_idx = (m_idx + 1) % 5;
    end
  endfunction

  // Per-cycle compare of every DUT output against the model.
  initial begin
    forever begin
      logic e_rxv, e_fe, e_busy;
      @(posedge clk);
      #2;
      e_rxv = (rxq.size() > 0) && (rxq[0].due == cyc);
      e_fe  = (feq.size() > 0) && (feq[0] == cyc);
      if (e_rxv) begin
        model_byte(rxq[0].b);
        void'(rxq.pop_front());
      end
      if (e_fe) void'(feq.pop_front());
      e_busy = rst_n && !ss_h2;
      ss_h2 = ss_h1;
      ss_h1 = bus.ss;
      check("rx_valid", bus.rx_valid, e_rxv);
      check("frame_err", bus.frame_err, e_fe);
      check("rx_data", bus.rx_data, m_rx);
      check("sys_state", bus.sys_state, m_state);
      check("sys_state_valid", bus.sys_state_valid, m_state_valid);
      check("busy", bus.busy, e_busy);
      if (!e_busy) check("miso_idle", bus.miso, 1'b0);
      if (bus.rx_valid) rxv_count++;
      if (bus.frame_err) fe_count++;
    end
  end

  initial begin
    #1600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ss_fall();
    bus.ss = 1'b0;
    tick(HALF);
  endtask

  task automatic ss_rise();
    tick(HALF);
    bus.ss = 1'b1;
    if (frame_bits % 8 != 0) feq.push_back(cyc + 3);
    frame_bits = 0;
    tick(HALF + 2);
  endtask

  // Shift nbits of b out on MOSI while collecting MISO as the master sees it.
  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] rcv);
    logic [7:0] exp;
    exp = model_resp();
    rcv = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = b[7-i];
      tick(HALF);
      rcv = {rcv[6:0], bus.miso};
      bus.spi_clk = 1'b1;
      frame_bits++;
      if (nbits == 8 && i == 7) rxq.push_back('{cyc + 3, b});
      tick(HALF);
      bus.spi_clk = 1'b0;
    end
    if (nbits == 8) check("miso_byte", rcv, exp);
  endtask

  task automatic frame1(input logic [7:0] b, output logic [7:0] rcv);
    ss_fall();
    xfer(b, 8, rcv);
    ss_rise();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rxq.delete();
    feq.delete();
    m_idx = 0;
    m_shadow = '0;
    m_rx = '0;
    m_state = '0;
    m_state_valid = 1'b0;
    frame_bits = 0;
    tick(4);
    check("rst_miso", bus.miso, 1'b0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_sys_state", bus.sys_state, 2'd0);
    check("rst_sys_state_valid", bus.sys_state_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    tick(4);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] uid_a[4];
    logic [7:0] uid_b[4];
    int c0, f0, nb;
    uid_a = '{8'h33, 8'h2C, 8'h1E, 8'hB7};
    uid_b = '{8'h33, 8'h6B, 8'hF4, 8'h10};
    bus.spi_clk = 1'b0;
    bus.ss = 1'b1;
    bus.mosi = 1'b0;
    bus.uid = '0;
    bus.uid_present = 1'b0;
    @(negedge clk);
    do_reset();

    // spi_clk activity with ss high must be ignored
    for (int i = 0; i < 8; i++) begin
      bus.spi_clk = ~bus.spi_clk;
      bus.mosi = 1'($urandom);
      tick(HALF);
    end
    check("idle_no_rx", 32'(rxv_count), 32'd0);
    check("idle_rx_data", bus.rx_data, 8'h00);

    // UID poll with a card present
    bus.uid = 32'h332C1EB7;
    bus.uid_present = 1'b1;
    c0 = rxv_count;
    frame1(8'hAA, r);
    check("poll_first_byte", r, 8'h00);
    for (int i = 0; i < 4; i++) begin
      frame1(8'h00, r);
      check("uid_a_byte", r, uid_a[i]);
    end
    check("poll_rx_pulses", 32'(rxv_count - c0), 32'd5);
    check("model_idx_back", 32'(m_idx), 32'd0);

    // No card: UID bytes read as zero
    bus.uid = $urandom;
    bus.uid_present = 1'b0;
    frame1(8'hAA, r);
    for (int i = 0; i < 4; i++) begin
      frame1(8'h00, r);
      check("no_card_byte", r, 8'h00);
    end

    // Snapshot holds while uid changes
    bus.uid = 32'h332C1EB7;
    bus.uid_present = 1'b1;
    frame1(8'hAA, r);
    bus.uid = 32'h336BF410;
    for (int i = 0; i < 4; i++) begin
      frame1(8'h00, r);
      check("snapshot_byte", r, uid_a[i]);
    end

    // State commands
    frame1(8'hBC, r);
    check("state_bc", bus.sys_state, 2'd2);
    check("state_bc_valid", bus.sys_state_valid, 1'b1);
    frame1(8'hBD, r);
    check("state_bd", bus.sys_state, 2'd3);
    frame1(8'h55, r);
    check("state_55_hold", bus.sys_state, 2'd3);
    check("rx_data_55", bus.rx_data, 8'h55);

    // Aborted byte then a clean poll
    c0 = rxv_count;
    f0 = fe_count;
    ss_fall();
    xfer(8'hA5, 5, r);
    ss_rise();
    check("abort_frame_err", 32'(fe_count - f0), 32'd1);
    check("abort_no_rx", 32'(rxv_count - c0), 32'd0);
    frame1(8'hAA, r);
    check("after_abort_rx", bus.rx_data, 8'hAA);
    frame1(8'h00, r);
    check("after_abort_uid1", r, 8'h33);
    frame1(8'h00, r);
    check("after_abort_uid2", r, 8'h6B);

    // Reset mid-UID, then a fresh poll starts from the top byte
    do_reset();
    frame1(8'hAA, r);
    frame1(8'h00, r);
    check("post_reset_uid1", r, 8'h33);
    for (int i = 0; i < 3; i++) frame1(8'h00, r);

    // Back-to-back bytes inside one frame
    ss_fall();
    xfer(8'hAA, 8, r);
    check("b2b_first", r, 8'h00);
    for (int i = 0; i < 4; i++) begin
      xfer(8'h00, 8, r);
      check("b2b_uid_byte", r, uid_b[i]);
    end
    ss_rise();

    // Random traffic against the model
    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      if ($urandom_range(0, 3) == 0) begin
        bus.uid = $urandom;
        bus.uid_present = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 24) == 0) do_reset();
      nb = $urandom_range(1, 3);
      ss_fall();
      for (int k = 0; k < nb; k++) begin
        case ($urandom_range(0, 5))
          0, 1:    b = 8'hAA;
          2:       b = 8'hBA + 8'($urandom_range(0, 3));
          default: b = 8'($urandom);
        endcase
        xfer(b, 8, r);
      end
      if ($urandom_range(0, 7) == 0) xfer(8'($urandom), $urandom_range(1, 7), r);
      ss_rise();
    end

    tick(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
